regtrace_serializer: RTL
========================

// Module: regtrace_serializer
// PURPOSE
//  Sits between the core writeback ports and the Cyclotron difftest sink.
//  Captures up to NUM_IN writeback trace records per cycle into a FIFO.
//  Replays them to the sink one per cycle, in strict order, as trace_* signals.
//  The sink has no backpressure. Records that do not fit are dropped and counted, never stalled.
// PARAMETERS
//  ARCH_LEN   32  lane data / PC width
//  NUM_LANES  16  lanes per register record
//  REG_BITS    8  register address width
//  NUM_IN      2  writeback ports sampled per cycle (1..4)
//  DEPTH       8  FIFO entries (power of 2, >= NUM_IN)
//  CNT_BITS   32  drop counter width
// PORTS
//  clock             in   1                          sole clock
//  reset             in   1                          synchronous, active-high
//  in_valid          in   NUM_IN                     record present on port i
//  in_pc             in   NUM_IN*ARCH_LEN            port i PC at [i*ARCH_LEN +: ARCH_LEN]
//  in_regs_enable    in   NUM_IN*3                   port i reg slot r at bit [i*3+r]
//  in_regs_address   in   NUM_IN*3*REG_BITS          same (i*3+r) slot order
//  in_regs_data      in   NUM_IN*3*NUM_LANES*ARCH_LEN  same slot order, lane 0 at LSBs
//  trace_valid       out  1                          record on trace_* this cycle
//  trace_pc          out  ARCH_LEN
//  trace_regs_{0,1,2}_enable   out  1
//  trace_regs_{0,1,2}_address  out  REG_BITS
//  trace_regs_{0,1,2}_data     out  NUM_LANES*ARCH_LEN
//  empty             out  1                          FIFO and output register both idle
//  overflow          out  1                          sticky: at least one record dropped
//  drop_count        out  CNT_BITS                   dropped records, saturating
// BEHAVIOUR
//  - Reset: all outputs are 0, except empty=1. FIFO pointers and count clear.
//    Reset mid-stream discards every buffered record and the output register.
//    Any record presented during the reset cycle is ignored.
//  - All trace_* outputs are registered.
//  - Each edge: if the FIFO is non-empty, the head pops into the output register with trace_valid=1.
//    Otherwise trace_valid=0. The data outputs then hold their last value and are don't-care.
//  - Latency: a record presented in cycle t is enqueued at the end of t.
//    Into an empty FIFO, it appears on trace_* in cycle t+2.
//  - Enqueue order within a cycle: ascending port index, over valid ports only.
//    Records land in consecutive slots with no holes.
//  - Space: free = DEPTH - count + pop. A same-cycle pop frees its slot.
//    If V valid records exceed free, the lowest-index ports up to free are accepted.
//    The rest are dropped.
//  - On a drop: drop_count += dropped, saturating at all-ones. overflow is set and stays set until reset.
//  - A record with all reg enables 0 is still a record: it is queued and emitted.
//  - Pointers: log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
//    full  = (count == DEPTH). empty FIFO = (count == 0).
//  - count' = count + accepted - pop. Never exceeds DEPTH. Never negative.
//  - empty = (count == 0) && !trace_valid.
// STRUCTURE
//  - regtrace_pkg:
//      typedef trace_rec_t = {pc, enable[3], address[3], data[3]}.
//      localparam REC_BITS.
//      function for in_* port slicing.
//  - Sub-module regtrace_mfifo:
//      NUM_IN-wide write, single read, accepts <= free per cycle.
//      Exports count and head.
//  - Top level: compaction/acceptance logic, output register, drop counter.
// TESTING
//  1. Port0 valid, pc=0x8000_0000, reg0 en addr=5, lane k data=k, at cycle 10
//     -> trace_valid=1 only in cycle 12 with identical fields; empty=1 again in cycle 13.
//  2. Ports 0 and 1 valid in the same cycle (pc 0x100, 0x104)
//     -> 0x100 emitted in cycle t+2, 0x104 in t+3.
//     Port1 valid alone -> sole record at t+2.
//  3. DEPTH=8; both ports valid every cycle for 10 cycles
//     -> accepted records emitted in strict pc order with no gaps.
//     overflow=1; drop_count = 20 minus emitted-or-buffered; count never > 8.
//  4. Steady 1 record/cycle for 3*DEPTH cycles
//     -> pointer wrap; every record emitted exactly once; drop_count=0.
//  5. Assert reset for 1 cycle with 5 records buffered
//     -> next cycle trace_valid=0, empty=1, overflow=0, drop_count=0.
//     No stale record ever appears afterwards.
//  6. Record with all enables 0, pc=0x200 -> emitted with trace_valid=1, enables 0.
//     Force drop_count near max -> saturates, does not wrap.

Source files
------------

// File: rtl/regtrace_pkg.sv
// Record layout and port-slicing helper shared by the writeback trace serializer.
package regtrace_pkg;

    localparam int ARCH_LEN       = 32;
    localparam int NUM_LANES      = 16;
    localparam int REG_BITS       = 8;
    localparam int NUM_SLOTS      = 3;
    localparam int SLOT_DATA_BITS = NUM_LANES * ARCH_LEN;
    localparam int MAX_IN         = 4;

    // Slot r of a record lives at index r of each packed array, lane 0 at the LSBs.
    typedef struct packed {
        logic [ARCH_LEN-1:0]                        pc;
        logic [NUM_SLOTS-1:0]                       enable;
        logic [NUM_SLOTS-1:0][REG_BITS-1:0]         address;
        logic [NUM_SLOTS-1:0][SLOT_DATA_BITS-1:0]   data;
    } trace_rec_t;

    localparam int REC_BITS = $bits(trace_rec_t);

    // Pulls the record of one writeback port out of the flattened input buses,
    // which are zero-extended to MAX_IN ports by the caller.
    function automatic trace_rec_t slice_port(
        input int                                           port,
        input logic [MAX_IN*ARCH_LEN-1:0]                   pc_bus,
        input logic [MAX_IN*NUM_SLOTS-1:0]                  en_bus,
        input logic [MAX_IN*NUM_SLOTS*REG_BITS-1:0]         addr_bus,
        input logic [MAX_IN*NUM_SLOTS*SLOT_DATA_BITS-1:0]   data_bus
    );
        trace_rec_t rec;
        rec.pc      = pc_bus[port*ARCH_LEN +: ARCH_LEN];
        rec.enable  = en_bus[port*NUM_SLOTS +: NUM_SLOTS];
        rec.address = addr_bus[port*NUM_SLOTS*REG_BITS +: NUM_SLOTS*REG_BITS];
        rec.data    = data_bus[port*NUM_SLOTS*SLOT_DATA_BITS +: NUM_SLOTS*SLOT_DATA_BITS];
        return rec;
    endfunction

endpackage

// File: rtl/regtrace_mfifo.sv
// Multi-write, single-read record FIFO. The caller decides which ports are
// accepted and their slot offsets; writes always land in consecutive slots.
module regtrace_mfifo
    import regtrace_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_IN-1:0]               wr_en,
    input  logic [NUM_IN-1:0][PTR_W-1:0]    wr_off,
    input  trace_rec_t [NUM_IN-1:0]         wr_data,
    input  logic [PTR_W-1:0]                wr_num,
    input  logic                            rd_en,
    output logic [PTR_W-1:0]                count,
    output trace_rec_t                      head
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [REC_BITS-1:0]            mem [DEPTH];
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [NUM_IN-1:0][ADDR_W-1:0]  wr_addr;

    // Each accepted port writes at the tail plus its offset among accepted ports.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            wr_addr[i] = ADDR_W'(wr_ptr + wr_off[i]);
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (!reset && wr_en[i]) begin
                mem[wr_addr[i]] <= wr_data[i];
            end
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + wr_num;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign head  = trace_rec_t'(mem[rd_ptr[ADDR_W-1:0]]);

endmodule

// File: rtl/regtrace_serializer.sv
// Captures up to NUM_IN writeback trace records per cycle and replays them one
// per cycle to a sink without backpressure; records that do not fit are dropped.
module regtrace_serializer
    import regtrace_pkg::*;
#(
    parameter int NUM_IN   = 2,
    parameter int DEPTH    = 8,
    parameter int CNT_BITS = 32
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_IN-1:0]                               in_valid,
    input  logic [NUM_IN*ARCH_LEN-1:0]                      in_pc,
    input  logic [NUM_IN*3-1:0]                             in_regs_enable,
    input  logic [NUM_IN*3*REG_BITS-1:0]                    in_regs_address,
    input  logic [NUM_IN*3*NUM_LANES*ARCH_LEN-1:0]          in_regs_data,
    output logic                                            trace_valid,
    output logic [ARCH_LEN-1:0]                             trace_pc,
    output logic                                            trace_regs_0_enable,
    output logic [REG_BITS-1:0]                             trace_regs_0_address,
    output logic [NUM_LANES*ARCH_LEN-1:0]                   trace_regs_0_data,
    output logic                                            trace_regs_1_enable,
    output logic [REG_BITS-1:0]                             trace_regs_1_address,
    output logic [NUM_LANES*ARCH_LEN-1:0]                   trace_regs_1_data,
    output logic                                            trace_regs_2_enable,
    output logic [REG_BITS-1:0]                             trace_regs_2_address,
    output logic [NUM_LANES*ARCH_LEN-1:0]                   trace_regs_2_data,
    output logic                                            empty,
    output logic                                            overflow,
    output logic [CNT_BITS-1:0]                             drop_count
);

    localparam int PTR_W  = $clog2(DEPTH) + 1;
    localparam int DROP_W = $clog2(NUM_IN + 1);

    trace_rec_t [NUM_IN-1:0]            port_rec;
    logic [NUM_IN-1:0]                  accept;
    logic [NUM_IN-1:0][PTR_W-1:0]       wr_off;
    logic [PTR_W-1:0]                   n_acc;
    logic [DROP_W-1:0]                  n_drop;
    logic [PTR_W-1:0]                   fifo_count;
    trace_rec_t                         fifo_head;
    logic                               pop;
    logic [PTR_W-1:0]                   free_slots;
    logic [CNT_BITS:0]                  drop_sum;
    logic [CNT_BITS-1:0]                drop_next;
    trace_rec_t                         out_rec;

    // Unpack each writeback port into a record.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            port_rec[i] = slice_port(i,
                                     (MAX_IN*ARCH_LEN)'(in_pc),
                                     (MAX_IN*NUM_SLOTS)'(in_regs_enable),
                                     (MAX_IN*NUM_SLOTS*REG_BITS)'(in_regs_address),
                                     (MAX_IN*NUM_SLOTS*SLOT_DATA_BITS)'(in_regs_data));
        end
    end

    // A pop in the same cycle frees its slot for an incoming record.
    assign pop        = (fifo_count != '0);
    assign free_slots = PTR_W'(DEPTH) - fifo_count + PTR_W'(pop);

    // Accept valid ports in ascending order until space runs out, compacting them.
    always_comb begin
        accept = '0;
        n_acc  = '0;
        n_drop = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            wr_off[i] = n_acc;
            if (in_valid[i]) begin
                if (n_acc < free_slots) begin
                    accept[i] = 1'b1;
                    n_acc     = n_acc + PTR_W'(1);
                end else begin
                    n_drop = n_drop + DROP_W'(1);
                end
            end
        end
    end

    regtrace_mfifo #(
        .NUM_IN (NUM_IN),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_off  (wr_off),
        .wr_data (port_rec),
        .wr_num  (n_acc),
        .rd_en   (pop),
        .count   (fifo_count),
        .head    (fifo_head)
    );

    // Output register: the FIFO head moves here whenever anything is buffered.
    always_ff @(posedge clock) begin
        if (reset) begin
            trace_valid <= 1'b0;
            out_rec     <= '0;
        end else if (pop) begin
            trace_valid <= 1'b1;
            out_rec     <= fifo_head;
        end else begin
            trace_valid <= 1'b0;
        end
    end

    assign drop_sum  = {1'b0, drop_count} + (CNT_BITS+1)'(n_drop);
    assign drop_next = drop_sum[CNT_BITS] ? '1 : drop_sum[CNT_BITS-1:0];

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (n_drop != '0) begin
            drop_count <= drop_next;
            overflow   <= 1'b1;
        end
    end

    assign trace_pc             = out_rec.pc;
    assign trace_regs_0_enable  = out_rec.enable[0];
    assign trace_regs_1_enable  = out_rec.enable[1];
    assign trace_regs_2_enable  = out_rec.enable[2];
    assign trace_regs_0_address = out_rec.address[0];
    assign trace_regs_1_address = out_rec.address[1];
    assign trace_regs_2_address = out_rec.address[2];
    assign trace_regs_0_data    = out_rec.data[0];
    assign trace_regs_1_data    = out_rec.data[1];
    assign trace_regs_2_data    = out_rec.data[2];
    assign empty                = (fifo_count == '0) && !trace_valid;

endmodule
